shift_sequencer: RTL and testbench
==================================

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 SHALL have parameter STEP_MAX, default 5: largest shift amount applied in one pass; legal range 1..5.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1: request present.
REQ-005 SHALL have port in_ready, output, 1: request accepted when in_valid && in_ready at a clock edge.
REQ-006 SHALL have port in_data, input, 32: operand.
REQ-007 SHALL have port in_amt, input, 5: total shift amount, 0..31.
REQ-008 SHALL have port in_dir, input, 1: 0 = left, 1 = right.
REQ-009 SHALL have port in_arith, input, 1: right shift fills with in_data[31] when 1 and with 0 when 0; ignored for left shifts.
REQ-010 SHALL have port out_valid, output, 1: result present.
REQ-011 SHALL have port out_ready, input, 1: consumer takes the result when out_valid && out_ready at a clock edge.
REQ-012 SHALL have port out_data, output, 32: shifted result.
REQ-013 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-014 SHALL implement the FSM states IDLE, SHIFT and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-016 On accept, SHALL latch the operand into acc, in_amt into rem, and latch dir and arith (sign = in_data[31]).
REQ-017 On accept, the next state SHALL be DONE if in_amt == 0; otherwise it SHALL be SHIFT.
REQ-018 Each SHIFT cycle SHALL compute step = min(rem, STEP_MAX), then update acc to acc shifted by step and rem to rem - step.
REQ-019 Left shifts SHALL feed acc directly to the 1..5 left-shift datapath.
REQ-020 Right shifts SHALL bit-reverse acc, left-shift it, then bit-reverse the result.
REQ-021 For arithmetic right shifts with sign = 1, the top step bits of acc SHALL be forced to 1 on each pass.
REQ-022 SHALL leave SHIFT for DONE on the edge where rem - step == 0.
REQ-023 Latency from the accept edge to the first cycle with out_valid = 1 SHALL be ceil(in_amt/STEP_MAX) + 1 cycles; amount 0 gives 1 cycle.
REQ-024 In DONE, out_data SHALL equal acc and SHALL hold stable, together with out_valid, until out_ready = 1.
REQ-025 The out handshake edge SHALL move the FSM to IDLE; a new request SHALL NOT be accepted in that same cycle.
REQ-026 in_* signals SHALL be ignored outside IDLE; the latched operands SHALL NOT change mid-operation.
REQ-027 Results SHALL be bit-exact to a reference 32-bit <<, >> and arithmetic >> for every amount from 0 to 31.
REQ-028 rem SHALL never underflow.
REQ-029 amount 31 with STEP_MAX 5 SHALL take 7 passes: six of 5 and one of 1.

Reset
REQ-030 reset SHALL force state = IDLE, acc = 0, rem = 0 and all latched flags to 0.
REQ-031 During and after reset, the outputs SHALL be in_ready = 1, out_valid = 0, out_data = 0 and busy = 0.
REQ-032 reset asserted in SHIFT or DONE SHALL abort the operation without emitting a result.
REQ-033 reset SHALL take priority over a simultaneous in or out handshake.

Structure
REQ-034 Package shift_pkg SHALL hold the state enum (IDLE/SHIFT/DONE), a direction enum (LEFT/RIGHT) and the constant STEP_MAX_DEF = 5.
REQ-035 SHALL instantiate exactly one sub-module, the existing left barrel shifter `shifter` (32-bit, exact amounts 1..5), as the per-pass datapath.
REQ-036 Bit reversal, sign fill and the step computation SHALL be local combinational logic.

Verification
REQ-037 Left shift: in_data 0x00000001, amt 12 -> out_data 0x00001000, out_valid 4 cycles after accept (passes 5, 5, 2).
REQ-038 Logical right shift: in_data 0x80000000, amt 31 -> out_data 0x00000001, latency 8.
REQ-039 Arithmetic right shift: in_data 0x80000000, amt 4 -> out_data 0xF8000000; the same case with in_arith 0 -> 0x08000000.
REQ-040 Amount zero: in_data 0xDEADBEEF, amt 0 -> out_data 0xDEADBEEF, latency 1.
REQ-041 Backpressure: hold out_ready 0 for 5 cycles in DONE -> out_data and out_valid stay stable, in_ready stays 0, and the next request is accepted only on or after the edge following the out handshake.
REQ-042 Abort: assert reset in the 2nd SHIFT cycle of amt 20 -> state IDLE next cycle, out_valid never rises, and a following request (amt 5) completes correctly.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types and constants for the multi-pass shift sequencer.
package shift_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef enum logic {
        LEFT  = 1'b0,
        RIGHT = 1'b1
    } dir_t;

    localparam int STEP_MAX_DEF = 5;

endpackage

// File: rtl/shifter.sv
// Single-pass 32-bit left barrel shifter used as the per-pass datapath.
module shifter (
    input  logic [31:0] d,
    input  logic [2:0]  amt,
    output logic [31:0] q
);

    assign q = d << amt;

endmodule

// File: rtl/shift_sequencer.sv
// Iterative shifter: applies up to STEP_MAX bits per cycle until the
// requested amount is consumed, with valid/ready on both sides.
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int STEP_MAX = STEP_MAX_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic [4:0]  in_amt,
    input  logic        in_dir,
    input  logic        in_arith,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy
);

    state_t      state;
    logic [31:0] acc;
    logic [4:0]  rem;
    dir_t        dir;
    logic        arith;
    logic        sign;

    logic [2:0]  step;
    logic [31:0] src;
    logic [31:0] shl;
    logic [31:0] fill;
    logic [31:0] nxt;

    function automatic logic [31:0] rev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

    always_comb begin
        step = 3'(STEP_MAX);
        if (rem < 5'(STEP_MAX)) begin
            step = rem[2:0];
        end
    end

    // Right shifts reuse the left shifter by mirroring in and out.
    assign src  = (dir == RIGHT) ? rev32(acc) : acc;
    assign fill = ~(32'hFFFF_FFFF >> step);

    shifter u_shifter (
        .d   (src),
        .amt (step),
        .q   (shl)
    );

    always_comb begin
        nxt = shl;
        if (dir == RIGHT) begin
            nxt = rev32(shl);
            if (arith && sign) begin
                nxt = nxt | fill;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            acc   <= '0;
            rem   <= '0;
            dir   <= LEFT;
            arith <= 1'b0;
            sign  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc   <= in_data;
                        rem   <= in_amt;
                        dir   <= dir_t'(in_dir);
                        arith <= in_arith;
                        sign  <= in_data[31];
                        state <= (in_amt == 5'd0) ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
                    acc <= nxt;
                    rem <= rem - 5'(step);
                    if (rem == 5'(step)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_data  = acc;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: reference-shift results, latency,
// backpressure and reset abort.
module tb_shift_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [4:0]  in_amt;
    logic        in_dir;
    logic        in_arith;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shift_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_dir    (in_dir),
        .in_arith  (in_arith),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [31:0] d,
                                              input logic [4:0] a,
                                              input logic dr,
                                              input logic ar);
        if (!dr) return d << a;
        if (ar) return 32'($signed(d) >>> a);
        return d >> a;
    endfunction

    // Accept one request, wait for the result, check it, then drain it.
    task automatic run(input string tag, input logic [31:0] d,
                       input logic [4:0] a, input logic dr, input logic ar);
        logic [31:0] exp;
        int          lat;
        int          exp_lat;
        exp     = ref_shift(d, a, dr, ar);
        exp_lat = (int'(a) + 4) / 5 + 1;
        chk({tag, "_ready"}, 32'(in_ready), 32'd1);
        in_data   = d;
        in_amt    = a;
        in_dir    = dr;
        in_arith  = ar;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 32'h5555_AAAA;
        in_amt   = 5'd17;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_data"}, out_data, exp);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_idle"}, {30'd0, in_ready, out_valid}, 32'd2);
    endtask

    initial begin
        logic [31:0] held;
        int          seen;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_amt    = '0;
        in_dir    = 1'b0;
        in_arith  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run("left12", 32'h0000_0001, 5'd12, 1'b0, 1'b0);
        run("lsr31", 32'h8000_0000, 5'd31, 1'b1, 1'b0);
        run("asr4", 32'h8000_0000, 5'd4, 1'b1, 1'b1);
        run("lsr4", 32'h8000_0000, 5'd4, 1'b1, 1'b0);
        run("zero", 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0);
        run("lsl_ar", 32'hF000_000F, 5'd7, 1'b0, 1'b1);
        run("asr_pos", 32'h7000_0001, 5'd9, 1'b1, 1'b1);

        for (int i = 0; i < 32; i++) begin
            run("sw_lsl", 32'hB3C5_1E97, 5'(i), 1'b0, 1'b0);
            run("sw_lsr", 32'hB3C5_1E97, 5'(i), 1'b1, 1'b0);
            run("sw_asr", 32'hB3C5_1E97, 5'(i), 1'b1, 1'b1);
        end

        // Backpressure: result held while a competing request waits.
        in_data  = 32'h1234_5678;
        in_amt   = 5'd3;
        in_dir   = 1'b0;
        in_arith = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_data = 32'h0000_00FF;
        in_amt  = 5'd0;
        seen = 0;
        while (out_valid !== 1'b1 && seen < 20) begin
            @(negedge clk);
            seen++;
        end
        chk("bp_reach_done", 32'(out_valid), 32'd1);
        held = out_data;
        chk("bp_data", held, 32'h91A2_B3C0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold", {out_data[31:3], out_valid, in_ready, 1'b0},
                {held[31:3], 1'b1, 1'b0, 1'b0});
            chk("bp_low", {29'd0, out_data[2:0]}, {29'd0, held[2:0]});
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_no_same_accept", {30'd0, busy, in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_next_accept", {30'd0, out_valid, busy}, 32'd3);
        chk("bp_next_data", out_data, 32'h0000_00FF);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;

        // Abort in the second SHIFT cycle.
        in_data  = 32'hCAFE_F00D;
        in_amt   = 5'd20;
        in_dir   = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("ab_in_shift", {30'd0, busy, out_valid}, 32'd2);
        reset     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset     = 1'b0;
        out_ready = 1'b0;
        chk("ab_idle", {30'd0, in_ready, busy}, 32'd2);
        chk("ab_data", out_data, 32'd0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen++;
        end
        chk("ab_no_result", 32'(seen), 32'd0);
        run("ab_after", 32'h0000_0003, 5'd5, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
